// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if
//   Bundles the ID-side capture inputs and the EX-side results of the
//   ID/EX operand stage.
//   master: decode stage side. It drives the id_* fields and observes the EX outputs.
//   slave : the operand stage. It consumes the id_* fields and drives alu_*, ex_* and load_use.
interface id_ex_operand_stage_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  // ID stage -> EX register
  logic               id_valid;
  logic [XLEN-1:0]    id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0]         id_alu_ctrl;
  logic [1:0]         id_src_a;
  logic               id_src_b;
  logic               id_reg_write, id_mem_read, id_mem_write;
  // EX stage results
  logic [XLEN-1:0]    alu_a, alu_b;
  logic [3:0]         alu_ctrl;
  logic               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [RADDR_W-1:0] ex_rd;
  logic [XLEN-1:0]    ex_pc, ex_store_data;
  logic               load_use;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_ctrl, id_src_a, id_src_b, id_reg_write, id_mem_read, id_mem_write,
    input  alu_a, alu_b, alu_ctrl, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_rd, ex_pc, ex_store_data, load_use
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_ctrl, id_src_a, id_src_b, id_reg_write, id_mem_read, id_mem_write,
    output alu_a, alu_b, alu_ctrl, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_rd, ex_pc, ex_store_data, load_use
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register for the 5-stage RV32I core. It also resolves the EX-stage
//   operand bypass from MEM and WB and selects the ALU a/b operands. It flags load-use
//   hazards so that IF/ID can hold.
// Ports
//   clk, rst_n       : clock; asynchronous active-low reset
//   stall, flush     : hold the EX register / load a bubble (flush wins)
//   bus (slave)      : id_* capture inputs, alu_a/alu_b/alu_ctrl, ex_* and load_use
//   mem_reg_write/mem_rd/mem_result : EX/MEM bypass source
//   wb_reg_write/wb_rd/wb_result    : MEM/WB bypass source
//   perf_bubble_cnt  : saturating count of bubbles loaded (only with ID_EX_PERF_CNT_EN)
// Configuration
//   ID_EX_PERF_CNT_EN : when defined, adds the perf_bubble_cnt output and its counter.
module id_ex_operand_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  id_ex_operand_stage_if.slave bus,
  input  logic               mem_reg_write,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]    mem_result,
  input  logic               wb_reg_write,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_result
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [3:0]         alu_ctrl;
    logic [1:0]         src_a;
    logic               src_b;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
  } ex_reg_t;

  ex_reg_t ex_q;
  logic    load_use;
  logic    bubble;

  // The load in EX delivers its data one stage too late for a dependent in ID.
  assign load_use = bus.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                    ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));

  // A flush always bubbles. A load-use bubble is suppressed while stalled, so the pair
  // is re-evaluated when the stall lifts and yields exactly one bubble.
  assign bubble = flush || (!stall && load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (bubble) begin
      ex_q.valid     <= 1'b0;
      ex_q.reg_write <= 1'b0;
      ex_q.mem_read  <= 1'b0;
      ex_q.mem_write <= 1'b0;
      ex_q.alu_ctrl  <= '0;
      ex_q.rd        <= '0;
    end else if (!stall) begin
      ex_q.valid     <= bus.id_valid;
      ex_q.reg_write <= bus.id_valid && bus.id_reg_write;
      ex_q.mem_read  <= bus.id_valid && bus.id_mem_read;
      ex_q.mem_write <= bus.id_valid && bus.id_mem_write;
      ex_q.alu_ctrl  <= bus.id_alu_ctrl;
      ex_q.src_a     <= bus.id_src_a;
      ex_q.src_b     <= bus.id_src_b;
      ex_q.rd        <= bus.id_rd;
      ex_q.rs1       <= bus.id_rs1;
      ex_q.rs2       <= bus.id_rs2;
      ex_q.pc        <= bus.id_pc;
      ex_q.rs1_data  <= bus.id_rs1_data;
      ex_q.rs2_data  <= bus.id_rs2_data;
      ex_q.imm       <= bus.id_imm;
    end
  end

  // Bypass: the youngest producer (MEM) wins, and x0 is never forwarded.
  logic            mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  assign mem_hit1 = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_q.rs1);
  assign mem_hit2 = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_q.rs2);
  assign wb_hit1  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_q.rs1);
  assign wb_hit2  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_q.rs2);

  assign fwd_rs1 = mem_hit1 ? mem_result : (wb_hit1 ? wb_result : ex_q.rs1_data);
  assign fwd_rs2 = mem_hit2 ? mem_result : (wb_hit2 ? wb_result : ex_q.rs2_data);

  always_comb begin
    bus.alu_a = fwd_rs1;
    case (ex_q.src_a)
      2'b01:   bus.alu_a = ex_q.pc;
      2'b10:   bus.alu_a = '0;
      default: bus.alu_a = fwd_rs1;
    endcase
  end

  assign bus.alu_b         = ex_q.src_b ? ex_q.imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.alu_ctrl      = ex_q.alu_ctrl;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_pc         = ex_q.pc;
  assign bus.load_use      = load_use;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_q <= '0;
    else if (bubble && (perf_q != 32'hFFFF_FFFF))
      perf_q <= perf_q + 32'd1;
  end

  assign perf_bubble_cnt = perf_q;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;
  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
`endif

  id_ex_operand_stage_if #(.XLEN(32), .RADDR_W(5)) bus ();

  id_ex_operand_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .bus(bus),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        vld, rw, mr, lu, ab;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic [31:0] a, b, sd;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_bub = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s got=%h expected=%h", nm, fld, got, want);
    end
  endtask

  // Monitor: each negedge, compare the DUT against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, "ex_valid", 32'(bus.ex_valid), 32'(e.vld));
      chk(e.name, "ex_rd", 32'(bus.ex_rd), 32'(e.rd));
      chk(e.name, "alu_ctrl", 32'(bus.alu_ctrl), 32'(e.ctrl));
      chk(e.name, "ex_reg_write", 32'(bus.ex_reg_write), 32'(e.rw));
      chk(e.name, "ex_mem_read", 32'(bus.ex_mem_read), 32'(e.mr));
      chk(e.name, "load_use", 32'(bus.load_use), 32'(e.lu));
      if (e.ab) begin
        chk(e.name, "alu_a", bus.alu_a, e.a);
        chk(e.name, "alu_b", bus.alu_b, e.b);
        chk(e.name, "store_data", bus.ex_store_data, e.sd);
      end
    end
  end

  task automatic push(input string nm, input logic vld, input logic [4:0] rd, input logic [3:0] ctrl,
                      input logic rw, input logic mr, input logic lu, input logic ab,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd);
    exp_t e;
    e.name = nm; e.vld = vld; e.rd = rd; e.ctrl = ctrl; e.rw = rw; e.mr = mr;
    e.lu = lu; e.ab = ab; e.a = a; e.b = b; e.sd = sd;
    exp_q.push_back(e);
  endtask

  task automatic bubble_exp(input string nm);
    push(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic id(input logic v, input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] r1d,
                    input logic [4:0] r2, input logic [31:0] r2d, input logic [31:0] imm,
                    input logic [4:0] rd, input logic [3:0] ctrl, input logic [1:0] sa,
                    input logic sb, input logic rw, input logic mr, input logic mw);
    bus.id_valid = v; bus.id_pc = pc; bus.id_rs1 = r1; bus.id_rs1_data = r1d;
    bus.id_rs2 = r2; bus.id_rs2_data = r2d; bus.id_imm = imm; bus.id_rd = rd;
    bus.id_alu_ctrl = ctrl; bus.id_src_a = sa; bus.id_src_b = sb;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
  endtask

  task automatic byp(input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                     input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
    mem_reg_write = mrw; mem_rd = mrd; mem_result = mres;
    wb_reg_write = wrw; wb_rd = wrd; wb_result = wres;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    byp(0, 0, 0, 0, 0, 0);
    step;
    push("reset0", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step;
    rst_n = 1'b1;
    id(1, 32'h100, 0, 0, 0, 0, 32'd7, 5, 0, 2'b00, 1, 1, 0, 0);           // ADDI x5,x0,7
    push("pre_capture", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step;
    id(1, 32'h104, 5, 32'h55, 5, 32'h55, 0, 6, 0, 2'b00, 0, 1, 0, 0);     // ADD x6,x5,x5
    push("addi", 1, 5, 0, 1, 0, 0, 1, 0, 32'd7, 0);
    step;
    byp(1, 5, 32'd7, 0, 0, 0);
    id(1, 32'h108, 5, 32'h11, 2, 32'h22, 0, 8, 0, 2'b00, 0, 1, 0, 0);
    push("mem_fwd", 1, 6, 0, 1, 0, 0, 1, 32'd7, 32'd7, 32'd7);
    step;
    byp(1, 5, 32'd1, 1, 5, 32'd2);
    id(1, 32'h10c, 0, 32'h33, 0, 32'h44, 0, 9, 0, 2'b00, 0, 1, 0, 0);
    push("mem_over_wb", 1, 8, 0, 1, 0, 0, 1, 32'd1, 32'h22, 32'h22);
    step;
    byp(1, 0, 32'd1, 1, 0, 32'd2);
    id(1, 32'h110, 5, 32'h5, 6, 32'h6, 0, 10, 0, 2'b00, 0, 1, 0, 0);
    push("x0_no_fwd", 1, 9, 0, 1, 0, 0, 1, 32'h33, 32'h44, 32'h44);
    step;
    byp(1, 6, 32'h60, 1, 5, 32'h50);
    id(1, 32'h200, 0, 0, 6, 32'h6, 32'h1000, 11, 0, 2'b01, 1, 1, 0, 0);
    push("wb_fwd", 1, 10, 0, 1, 0, 0, 1, 32'h50, 32'h60, 32'h60);
    step;
    byp(1, 6, 32'h66, 0, 0, 0);
    id(1, 32'h204, 5, 32'h5, 0, 32'h7, 32'hABC, 12, 4'hA, 2'b10, 1, 1, 0, 0);
    push("src_pc", 1, 11, 0, 1, 0, 0, 1, 32'h200, 32'h1000, 32'h66);
    step;
    byp(1, 5, 32'h99, 0, 0, 0);
    id(1, 32'h208, 1, 32'h1000, 0, 0, 0, 3, 0, 2'b00, 1, 1, 1, 0);       // LW x3,0(x1)
    push("src_zero", 1, 12, 4'hA, 1, 0, 0, 1, 0, 32'hABC, 32'h7);
    step;
    byp(0, 0, 0, 0, 0, 0);
    id(1, 32'h20c, 3, 32'hDEAD, 1, 32'h1000, 0, 4, 0, 2'b00, 0, 1, 0, 0); // ADD x4,x3,x1
    push("lw_load_use", 1, 3, 0, 1, 1, 1, 1, 32'h1000, 0, 0);
    exp_bub++;
    step;
    bubble_exp("lu_bubble");
    step;
    byp(0, 0, 0, 1, 3, 32'hCAFE);
    push("lu_wb_fwd", 1, 4, 0, 1, 0, 0, 1, 32'hCAFE, 32'h1000, 32'h1000);
    stall = 1'b1; flush = 1'b1;
    id(1, 32'h210, 1, 32'h10, 2, 32'h3, 0, 13, 4'h1, 2'b00, 0, 1, 0, 0);  // SUB x13,x1,x2
    exp_bub++;
    step;
    stall = 1'b0; flush = 1'b0;
    byp(0, 0, 0, 0, 0, 0);
    bubble_exp("stall_flush");
    step;
    push("sub", 1, 13, 4'h1, 1, 0, 0, 1, 32'h10, 32'h3, 32'h3);
    stall = 1'b1;
    id(1, 32'h214, 7, 32'h77, 7, 32'h77, 0, 15, 4'h2, 2'b00, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step;
      push("stall_hold", 1, 13, 4'h1, 1, 0, 0, 1, 32'h10, 32'h3, 32'h3);
    end
    stall = 1'b0;
    step;
    push("after_stall", 1, 15, 4'h2, 1, 0, 0, 1, 32'h77, 32'h77, 32'h77);
    flush = 1'b1;
    exp_bub++;
    step;
    flush = 1'b0;
    bubble_exp("flush");
    id(0, 32'h218, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, 1);
    step;
    push("id_invalid", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    id(1, 32'h21c, 1, 32'h20, 0, 0, 32'd4, 0, 0, 2'b00, 1, 1, 1, 0);     // LW x0,4(x1)
    step;
    id(1, 32'h220, 0, 0, 0, 0, 0, 14, 0, 2'b00, 0, 1, 0, 0);              // ADD x14,x0,x0
    push("lw_x0", 1, 0, 0, 1, 1, 0, 1, 32'h20, 32'd4, 0);
    step;
    push("no_lu_x0", 1, 14, 0, 1, 0, 0, 1, 0, 0, 0);
`ifdef ID_EX_PERF_CNT_EN
    chk("perf", "bubble_cnt", perf_bubble_cnt, 32'(exp_bub));
`endif
    id(1, 32'h300, 0, 32'h1, 0, 32'h2, 0, 16, 0, 2'b00, 0, 1, 0, 0);
    step;
    #1;
    rst_n = 1'b0;
    push("reset_mid", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
`ifdef ID_EX_PERF_CNT_EN
    #1;
    chk("perf_reset", "bubble_cnt", perf_bubble_cnt, 32'd0);
`endif
    step;
    rst_n = 1'b1;
    push("release_hold", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step;
    push("first_capture", 1, 16, 0, 1, 0, 0, 1, 32'h1, 32'h2, 32'h2);
    step;
    step;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
